// File: rtl/epp_pkg.sv
// epp_pkg: EPP op and host state encodings shared by host and peripheral
package epp_pkg;
  localparam logic [1:0] OP_ADDR_WR = 2'b00;
  localparam logic [1:0] OP_ADDR_RD = 2'b01;
  localparam logic [1:0] OP_DATA_WR = 2'b10;
  localparam logic [1:0] OP_DATA_RD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RELEASE} host_state_t;
endpackage

// File: rtl/epp_sync.sv
// epp_sync: SYNC_STAGES-deep reset-to-0 synchronizer (clk, rst_n, d async in, q synced out)
module epp_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  end
  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/epp_host.sv
// epp_host: EPP host initiator; cmd valid/ready in, rsp pulse out, drives Astb/Dstb/Wr/Db paced by Wait; EPP_HOST_TIMEOUT_EN adds timeout abort
module epp_host
  import epp_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  inout  wire  [7:0] Db,
  output logic       Astb,
  output logic       Dstb,
  output logic       Wr,
  input  logic       Wait
);
  localparam int SW = $clog2(SETUP_CYC + 1);
  host_state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic wr_q, wr_d, astb_q, astb_d, dstb_q, dstb_d, oe_q, oe_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0] dout_q, dout_d, rdata_q, rdata_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic wait_s, advance, timeout;
  epp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(Wait), .q(wait_s));
  assign advance = state_q == ST_IDLE  ? cmd_valid :
                   state_q == ST_SETUP ? (scnt_q == '0 && !wait_s) :
                   state_q == ST_STROBE ? wait_s : !wait_s;
`ifdef EPP_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic counting;
  assign counting = state_q != ST_IDLE && !(state_q == ST_SETUP && scnt_q != '0);
  assign timeout = counting && !advance && tcnt_q == TW'(TIMEOUT_CYC - 1);
  assign tcnt_d = (advance || !counting) ? '0 :
                  tcnt_q == TW'(TIMEOUT_CYC) ? tcnt_q : tcnt_q + TW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_q <= '0;
    else tcnt_q <= tcnt_d;
  end
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    wr_d = wr_q;
    astb_d = astb_q;
    dstb_d = dstb_q;
    oe_d = oe_q;
    dout_d = dout_q;
    rdata_d = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d = 1'b0;
    scnt_d = scnt_q == '0 ? scnt_q : scnt_q - SW'(1);
    if (timeout) begin
      state_d = ST_IDLE;
      astb_d = 1'b1;
      dstb_d = 1'b1;
      wr_d = 1'b1;
      oe_d = 1'b0;
      rdata_d = 8'h00;
      rsp_valid_d = 1'b1;
      rsp_err_d = 1'b1;
    end else if (advance) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETUP;
          op_d = cmd_op;
          wr_d = cmd_op[0];
          oe_d = !cmd_op[0];
          dout_d = cmd_wdata;
          rdata_d = 8'h00;
          scnt_d = SW'(SETUP_CYC);
        end
        ST_SETUP: begin
          state_d = ST_STROBE;
          astb_d = op_q[1];
          dstb_d = !op_q[1];
        end
        ST_STROBE: begin
          state_d = ST_RELEASE;
          astb_d = 1'b1;
          dstb_d = 1'b1;
          rdata_d = op_q[0] ? Db : rdata_q;
        end
        default: begin
          state_d = ST_IDLE;
          wr_d = 1'b1;
          oe_d = 1'b0;
          rsp_valid_d = 1'b1;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q <= 2'b00;
      wr_q <= 1'b1;
      astb_q <= 1'b1;
      dstb_q <= 1'b1;
      oe_q <= 1'b0;
      dout_q <= 8'h00;
      rdata_q <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      scnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      wr_q <= wr_d;
      astb_q <= astb_d;
      dstb_q <= dstb_d;
      oe_q <= oe_d;
      dout_q <= dout_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      scnt_q <= scnt_d;
    end
  end
  assign cmd_ready = state_q == ST_IDLE;
  assign busy = state_q != ST_IDLE;
  assign Db = oe_q ? dout_q : 8'hzz;
  assign Astb = astb_q;
  assign Dstb = dstb_q;
  assign Wr = wr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_epp_host.sv
// tb_epp_host: self-checking bench for epp_host with an EPP peripheral model and response scoreboard
module tb_epp_host;
  import epp_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_err, busy;
  logic [1:0] cmd_op = 2'b00, mode = 2'b00;
  logic [7:0] cmd_wdata = 8'h00, rsp_rdata;
  logic Astb, Dstb, Wr, Wait;
  wire [7:0] Db;
  logic [7:0] p_addr = 8'h00, p_data = 8'h00, p_drv = 8'h00;
  logic p_oe = 1'b0, wait_i = 1'b0;
  int passed = 0, total = 0, rsp_cnt = 0, astb_falls = 0, dstb_falls = 0;
  typedef struct packed {logic [7:0] rdata; logic err;} exp_t;
  exp_t exp_q[$];
  typedef struct {logic [1:0] op; logic [7:0] wd; logic [7:0] rd; logic [7:0] reg_exp;} vec_t;
  vec_t vec[8];

  always #5 clk = ~clk;

  epp_host #(.SETUP_CYC(2), .TIMEOUT_CYC(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .Db(Db), .Astb(Astb), .Dstb(Dstb), .Wr(Wr), .Wait(Wait)
  );

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (Db[g]);
  end
  assign Db = p_oe ? p_drv : 8'hzz;
  assign Wait = mode == 2'd1 ? 1'b0 : mode == 2'd2 ? 1'b1 : wait_i;

  always @(posedge clk) begin
    if (mode == 2'd0) begin
      if (!Astb || !Dstb) begin
        if (!wait_i) begin
          if (Wr) begin
            p_drv <= Astb ? p_data : p_addr;
            p_oe <= 1'b1;
          end else if (!Astb) p_addr <= Db;
          else p_data <= Db;
          wait_i <= 1'b1;
        end
      end else begin
        wait_i <= 1'b0;
        p_oe <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      exp_t e;
      rsp_cnt++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  logic [7:0] db_prev = 8'hFF;
  logic wr_prev = 1'b1, astb_prev = 1'b1, dstb_prev = 1'b1;
  int stable = 0;
  always @(negedge clk) begin
    if (Wr !== wr_prev || Db !== db_prev) stable = 0;
    else stable++;
    if (rst_n) begin
      if ((astb_prev && !Astb) || (dstb_prev && !Dstb)) begin
        chk("setup_stable", stable >= 2, 1'b1);
        chk("one_strobe", Astb ^ Dstb, 1'b1);
      end
      if (astb_prev && !Astb) astb_falls++;
      if (dstb_prev && !Dstb) dstb_falls++;
      if (mode == 2'd0 && ((!astb_prev && Astb) || (!dstb_prev && Dstb))) chk("rise_after_wait", Wait, 1'b1);
    end
    wr_prev = Wr;
    db_prev = Db;
    astb_prev = Astb;
    dstb_prev = Dstb;
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] wd, input logic [7:0] er,
                       input logic ee, input logic keep, input logic push);
    int n = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_wdata = wd;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", n < 300, 1'b1);
    if (push) exp_q.push_back('{er, ee});
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    chk("busy_after_accept", {cmd_ready, busy, Wr}, {2'b01, op[0]});
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    int a0, d0, r0, n, lo;
    vec[0] = '{OP_ADDR_WR, 8'h5A, 8'h00, 8'h5A};
    vec[1] = '{OP_DATA_WR, 8'hC3, 8'h00, 8'hC3};
    vec[2] = '{OP_DATA_RD, 8'h00, 8'hC3, 8'hC3};
    vec[3] = '{OP_ADDR_RD, 8'h00, 8'h5A, 8'h5A};
    vec[4] = '{OP_DATA_WR, 8'h3C, 8'h00, 8'h3C};
    vec[5] = '{OP_ADDR_WR, 8'hA5, 8'h00, 8'hA5};
    vec[6] = '{OP_DATA_RD, 8'h00, 8'h3C, 8'h3C};
    vec[7] = '{OP_ADDR_RD, 8'h00, 8'hA5, 8'hA5};
    #12;
    chk("reset_bus", {Astb, Dstb, Wr, Db}, {3'b111, 8'hFF});
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
    chk("reset_ready", {cmd_ready, busy}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      a0 = astb_falls;
      d0 = dstb_falls;
      issue(vec[i].op, vec[i].wd, vec[i].rd, 1'b0, 1'b0, 1'b1);
      chk("db_drive", Db, vec[i].op[0] ? 8'hFF : vec[i].wd);
      wait_rsp();
      chk("astb_falls", astb_falls - a0, {31'd0, !vec[i].op[1]});
      chk("dstb_falls", dstb_falls - d0, {31'd0, vec[i].op[1]});
      chk("model_reg", vec[i].op[1] ? p_data : p_addr, vec[i].reg_exp);
      chk("idle_bus", {Astb, Dstb, Wr, Db}, {3'b111, 8'hFF});
    end

    r0 = rsp_cnt;
    issue(OP_ADDR_WR, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1);
    issue(OP_DATA_WR, 8'h22, 8'h00, 1'b0, 1'b1, 1'b1);
    issue(OP_DATA_RD, 8'h00, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_rsp();
    repeat (3) @(negedge clk);
    chk("b2b_rsp_count", rsp_cnt - r0, 3);
    chk("b2b_addr", p_addr, 8'h11);

    mode = 2'd1;
    r0 = rsp_cnt;
`ifdef EPP_HOST_TIMEOUT_EN
    issue(OP_DATA_WR, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (Dstb && n < 50) begin
      @(negedge clk);
      n++;
    end
    lo = 0;
    while (!Dstb && lo < 100) begin
      @(negedge clk);
      lo++;
    end
    chk("dstb_low_cycles", lo >= 15 && lo <= 17, 1'b1);
    wait_rsp();
    chk("timeout_bus", {Astb, Dstb, Wr, Db}, {3'b111, 8'hFF});
    chk("timeout_rsp_count", rsp_cnt - r0, 1);
`else
    issue(OP_DATA_WR, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("dstb_held_low", {Dstb, Astb, busy}, 3'b011);
    chk("no_rsp_while_stuck", rsp_cnt - r0, 0);
    do_reset();
`endif

    issue(OP_DATA_WR, 8'h66, 8'h00, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (Dstb && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("dstb_low_before_rst", Dstb, 1'b0);
    r0 = rsp_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {Astb, Dstb, Wr, Db, busy}, {3'b111, 8'hFF, 1'b0});
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    mode = 2'd0;
    repeat (6) @(negedge clk);
    chk("no_rsp_after_rst", rsp_cnt - r0, 0);
    issue(OP_ADDR_WR, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_rsp();
    chk("post_rst_addr", p_addr, 8'h77);

    mode = 2'd2;
    repeat (4) @(negedge clk);
    a0 = astb_falls;
    d0 = dstb_falls;
    r0 = rsp_cnt;
`ifdef EPP_HOST_TIMEOUT_EN
    issue(OP_DATA_WR, 8'hAA, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_rsp();
    chk("stuck_rsp_count", rsp_cnt - r0, 1);
`else
    issue(OP_DATA_WR, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("stuck_busy", {busy, Astb, Dstb}, 3'b111);
    chk("stuck_no_rsp", rsp_cnt - r0, 0);
    do_reset();
`endif
    chk("stuck_no_strobe", (astb_falls - a0) + (dstb_falls - d0), 0);
    mode = 2'd0;
    repeat (4) @(negedge clk);
    issue(OP_DATA_RD, 8'h00, 8'h22, 1'b0, 1'b0, 1'b1);
    wait_rsp();
    chk("final_idle", {cmd_ready, busy, Astb, Dstb, Wr}, 5'b10111);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
